// File: rtl/mes_amp_period_n_pkg.sv
// Shared definitions for the period/amplitude measurement block:
// FSM state encoding, midpoint helper and saturating counter increment.
package mes_amp_period_n_pkg;

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  // Offset-binary midpoint for a w-bit sample.
  function automatic int mid_of(input int w);
    return 32'sd1 << (w - 32'sd1);
  endfunction

  // Increment that sticks at lim instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] lim);
    logic [31:0] r;
    if (v >= lim) r = lim;
    else          r = v + 32'd1;
    return r;
  endfunction

endpackage

// File: rtl/mes_amp_period_n_hyst_cmp.sv
// Hysteresis zero-crossing comparator around the offset-binary midpoint.
// o_rise/o_fall are single-cycle pulses valid in the strobed cycle that
// flips the comparator; the comparator state itself is registered.
module mes_amp_period_n_hyst_cmp
  import mes_amp_period_n_pkg::*;
#(
  parameter int W    = 12,
  parameter int HYST = 16
) (
  input  logic         clk,
  input  logic         i_nrst,
  input  logic         i_ce,
  input  logic [W-1:0] i_x,
  output logic         o_zx,
  output logic         o_rise,
  output logic         o_fall
);

  localparam logic [W-1:0] TH_HI = W'(mid_of(W) + HYST);
  localparam logic [W-1:0] TH_LO = W'(mid_of(W) - HYST);

  logic r_zx;
  logic w_set;
  logic w_clr;

  assign w_set  = (i_x >= TH_HI);
  assign w_clr  = (i_x <= TH_LO);
  assign o_rise = i_ce & ~r_zx & w_set;
  assign o_fall = i_ce &  r_zx & w_clr;
  assign o_zx   = r_zx;

  // Comparator state: flips only on a strobed sample outside the band, holds inside it
  always_ff @(posedge clk or negedge i_nrst) begin
    if (!i_nrst)     r_zx <= 1'b0;
    else if (o_rise) r_zx <= 1'b1;
    else if (o_fall) r_zx <= 1'b0;
    else             r_zx <= r_zx;
  end

endmodule

// File: rtl/mes_amp_period_n.sv
// Period / positive half-period / peak / trough / amplitude measurement of an
// offset-binary sample stream, averaged over 2^AVG periods. Results and both
// strobes register one clk after the ce that completes a period.
module mes_amp_period_n
  import mes_amp_period_n_pkg::*;
#(
  parameter int W    = 12,
  parameter int CW   = 12,
  parameter int HYST = 16,
  parameter int AVG  = 0
) (
  input  logic          clk,
  input  logic          NRST,
  input  logic          ce,
  input  logic          ext_res,
  input  logic [W-1:0]  X,
  output logic [CW-1:0] NTfr,
  output logic [CW-1:0] NTsp,
  output logic [W-1:0]  PIC,
  output logic [W-1:0]  VAL,
  output logic [W-1:0]  AMP,
  output logic          zX,
  output logic          end_Tfr,
  output logic          end_Tsp,
  output logic          ovf
);

  localparam int AFW = CW + AVG;
  localparam int AXW = W + AVG;
  localparam int PW  = (AVG > 0) ? AVG : 1;
  localparam logic [PW-1:0] P_LAST  = PW'((32'd1 << AVG) - 32'd1);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [31:0]   CNT_LIM = 32'(CNT_MAX);

  state_t          r_state;
  logic [CW-1:0]   r_cnt_fr, r_cnt_sp, r_tsp;
  logic [W-1:0]    r_max, r_min;
  logic [AFW-1:0]  r_acc_fr, r_acc_sp;
  logic [AXW-1:0]  r_acc_max, r_acc_min;
  logic [PW-1:0]   r_p;
  logic [CW-1:0]   r_ntfr, r_ntsp;
  logic [W-1:0]    r_pic, r_val, r_amp;
  logic            r_end, r_ovf;

  logic            w_ce_eff, w_zx, w_rise, w_fall;
  logic [CW-1:0]   w_fr_inc, w_sp_inc;
  logic            w_fr_full, w_complete, w_timeout, w_wrap, w_publish;
  logic [AFW-1:0]  w_sum_fr, w_sum_sp;
  logic [AXW-1:0]  w_sum_max, w_sum_min;
  logic [CW-1:0]   w_pub_fr, w_pub_sp;
  logic [W-1:0]    w_pub_pic, w_pub_val, w_pub_amp;

  // A sample strobed together with a restart is discarded, also by the comparator.
  assign w_ce_eff = ce & ~ext_res;

  mes_amp_period_n_hyst_cmp #(
    .W    (W),
    .HYST (HYST)
  ) u_hyst_cmp (
    .clk    (clk),
    .i_nrst (NRST),
    .i_ce   (w_ce_eff),
    .i_x    (X),
    .o_zx   (w_zx),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  assign w_fr_inc   = CW'(sat_inc(32'(r_cnt_fr), CNT_LIM));
  assign w_sp_inc   = CW'(sat_inc(32'(r_cnt_sp), CNT_LIM));
  // cnt_sp never exceeds cnt_fr, so a saturated frame counter covers both.
  assign w_fr_full  = (w_fr_inc == CNT_MAX);
  assign w_complete = w_rise & (r_state == ST_LOW);
  assign w_timeout  = w_ce_eff & w_fr_full & ~w_rise;
  assign w_wrap     = (r_p == P_LAST) | w_fr_full;
  assign w_publish  = w_timeout | (w_complete & w_wrap);

  // Candidate published values: averaged result, or all-ones plus last extremes on saturation
  always_comb begin
    w_sum_fr  = r_acc_fr  + AFW'(w_fr_inc);
    w_sum_sp  = r_acc_sp  + AFW'(r_tsp);
    w_sum_max = r_acc_max + AXW'(r_max);
    w_sum_min = r_acc_min + AXW'(r_min);
    if (w_fr_full) begin
      w_pub_fr  = CNT_MAX;
      w_pub_sp  = CNT_MAX;
      w_pub_pic = r_max;
      w_pub_val = r_min;
    end else begin
      w_pub_fr  = CW'(w_sum_fr  >> AVG);
      w_pub_sp  = CW'(w_sum_sp  >> AVG);
      w_pub_pic = W'(w_sum_max >> AVG);
      w_pub_val = W'(w_sum_min >> AVG);
    end
    w_pub_amp = (w_pub_pic - w_pub_val) >> 1'b1;
  end

  // Measurement FSM with per-period counters, averaging accumulators and registered results
  always_ff @(posedge clk or negedge NRST) begin
    if (!NRST) begin
      r_state   <= ST_SYNC;
      r_cnt_fr  <= {CW{1'b0}};
      r_cnt_sp  <= {CW{1'b0}};
      r_tsp     <= {CW{1'b0}};
      r_max     <= {W{1'b0}};
      r_min     <= {W{1'b0}};
      r_acc_fr  <= {AFW{1'b0}};
      r_acc_sp  <= {AFW{1'b0}};
      r_acc_max <= {AXW{1'b0}};
      r_acc_min <= {AXW{1'b0}};
      r_p       <= {PW{1'b0}};
      r_ntfr    <= {CW{1'b0}};
      r_ntsp    <= {CW{1'b0}};
      r_pic     <= {W{1'b0}};
      r_val     <= {W{1'b0}};
      r_amp     <= {W{1'b0}};
      r_end     <= 1'b0;
      r_ovf     <= 1'b0;
    end else if (ext_res) begin
      // Restart measurement but keep the last published results visible.
      r_state   <= ST_SYNC;
      r_cnt_fr  <= {CW{1'b0}};
      r_cnt_sp  <= {CW{1'b0}};
      r_tsp     <= {CW{1'b0}};
      r_acc_fr  <= {AFW{1'b0}};
      r_acc_sp  <= {AFW{1'b0}};
      r_acc_max <= {AXW{1'b0}};
      r_acc_min <= {AXW{1'b0}};
      r_p       <= {PW{1'b0}};
      r_end     <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_end <= w_publish;
      if (w_publish) begin
        r_ntfr    <= w_pub_fr;
        r_ntsp    <= w_pub_sp;
        r_pic     <= w_pub_pic;
        r_val     <= w_pub_val;
        r_amp     <= w_pub_amp;
        r_ovf     <= w_fr_full;
        r_acc_fr  <= {AFW{1'b0}};
        r_acc_sp  <= {AFW{1'b0}};
        r_acc_max <= {AXW{1'b0}};
        r_acc_min <= {AXW{1'b0}};
        r_p       <= {PW{1'b0}};
      end else if (w_complete) begin
        r_acc_fr  <= w_sum_fr;
        r_acc_sp  <= w_sum_sp;
        r_acc_max <= w_sum_max;
        r_acc_min <= w_sum_min;
        r_p       <= r_p + PW'(1'b1);
      end
      if (ce) begin
        case (r_state)
          ST_SYNC: begin
            // The frame counter doubles as the no-crossing timeout while syncing.
            if (w_rise) begin
              r_cnt_fr <= {CW{1'b0}};
              r_cnt_sp <= {CW{1'b0}};
              r_max    <= X;
              r_min    <= X;
              r_state  <= ST_HIGH;
            end else if (w_timeout) begin
              r_cnt_fr <= {CW{1'b0}};
            end else begin
              r_cnt_fr <= w_fr_inc;
            end
          end
          ST_HIGH: begin
            if (w_timeout) begin
              r_cnt_fr <= {CW{1'b0}};
              r_cnt_sp <= {CW{1'b0}};
              r_state  <= ST_SYNC;
            end else begin
              r_cnt_fr <= w_fr_inc;
              r_cnt_sp <= w_sp_inc;
              r_max    <= (X > r_max) ? X : r_max;
              r_min    <= (X < r_min) ? X : r_min;
              if (w_fall) begin
                r_tsp   <= w_sp_inc;
                r_state <= ST_LOW;
              end
            end
          end
          ST_LOW: begin
            if (w_complete) begin
              // The completing sample is tick 0 of the next period.
              r_cnt_fr <= {CW{1'b0}};
              r_cnt_sp <= {CW{1'b0}};
              r_max    <= X;
              r_min    <= X;
              r_state  <= ST_HIGH;
            end else if (w_timeout) begin
              r_cnt_fr <= {CW{1'b0}};
              r_cnt_sp <= {CW{1'b0}};
              r_state  <= ST_SYNC;
            end else begin
              r_cnt_fr <= w_fr_inc;
              r_max    <= (X > r_max) ? X : r_max;
              r_min    <= (X < r_min) ? X : r_min;
            end
          end
          default: begin
            r_state <= ST_SYNC;
          end
        endcase
      end
    end
  end

  assign NTfr    = r_ntfr;
  assign NTsp    = r_ntsp;
  assign PIC     = r_pic;
  assign VAL     = r_val;
  assign AMP     = r_amp;
  assign zX      = w_zx;
  assign end_Tfr = r_end;
  assign end_Tsp = r_end;
  assign ovf     = r_ovf;

endmodule
